// File: rtl/adc_capture_pkg.sv
// adc_capture_pkg
//   Shared definitions for the measurement capture path: FSM state
//   encoding, default parameter values, CPU I/O register bit positions
//   and a counter-width helper.
package adc_capture_pkg;

    // Default build parameters
    localparam int DEF_ADC_BITS          = 10;
    localparam int DEF_AVG_LOG2          = 2;
    localparam int DEF_DIV_HALF          = 2;
    localparam int DEF_CONV_WAIT         = 8;
    localparam int DEF_GENERAL_REG_WIDTH = 16;

    // Measurement start bit in io_control, done bit in io_status
    localparam int IO_MEAS_STA      = 7;
    localparam int IO_STA_MEAS_DONE = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONV,
        ST_WAIT,
        ST_SHIFT,
        ST_ACCUM,
        ST_DONE
    } meas_state_e;

    // Bits needed to hold values 0..max_val (at least 1)
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/adc_sample_accum_if.sv
// adc_sample_accum_if
//   CPU-side measurement handshake.
//   meas_start   : level request, rising edge starts a run (master -> slave)
//   meas_busy    : run in progress                       (slave -> master)
//   meas_is_done : result valid, level until next start  (slave -> master)
//   meas_result  : averaged result, zero-extended        (slave -> master)
interface adc_sample_accum_if #(
    parameter int GENERAL_REG_WIDTH = adc_capture_pkg::DEF_GENERAL_REG_WIDTH
);
    logic                         meas_start;
    logic                         meas_busy;
    logic                         meas_is_done;
    logic [GENERAL_REG_WIDTH-1:0] meas_result;

    modport master (
        output meas_start,
        input  meas_busy,
        input  meas_is_done,
        input  meas_result
    );

    modport slave (
        input  meas_start,
        output meas_busy,
        output meas_is_done,
        output meas_result
    );
endinterface

// File: rtl/adc_serial_rx.sv
// adc_serial_rx
//   Serial ADC reader: generates SCLK from a DIV_HALF divider and shifts
//   ana_si in MSB-first on every SCLK rising edge.
//   clk, rst_n : clock, async active-low reset
//   start      : one-cycle pulse, begins a word (SCLK starts low)
//   ana_si     : ADC serial data
//   done       : high in the last cycle of the word (last high half-period)
//   sclk       : serial clock to the ADC
//   data       : received word, valid when done is high
module adc_serial_rx
    import adc_capture_pkg::*;
#(
    parameter int ADC_BITS = DEF_ADC_BITS,
    parameter int DIV_HALF = DEF_DIV_HALF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                ana_si,
    output logic                done,
    output logic                sclk,
    output logic [ADC_BITS-1:0] data
);
    localparam int DIV_W = cnt_width(DIV_HALF - 1);
    localparam int BIT_W = cnt_width(ADC_BITS);
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(DIV_HALF - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(ADC_BITS);

    logic             active;
    logic [DIV_W-1:0] div_cnt;
    logic [BIT_W-1:0] bit_cnt;

    // The word ends on the falling edge after the last rise, so the
    // caller sees done while SCLK is still high and leaves with SCLK low.
    assign done = active && sclk && (div_cnt == '0) && (bit_cnt == BIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active  <= 1'b0;
            sclk    <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            data    <= '0;
        end else if (start) begin
            active  <= 1'b1;
            sclk    <= 1'b0;
            div_cnt <= DIV_LOAD;
            bit_cnt <= '0;
        end else if (active) begin
            if (div_cnt == '0) begin
                div_cnt <= DIV_LOAD;
                if (!sclk) begin
                    sclk    <= 1'b1;
                    data    <= ADC_BITS'({data, ana_si});
                    bit_cnt <= bit_cnt + BIT_W'(1);
                end else begin
                    sclk <= 1'b0;
                    if (bit_cnt == BIT_LAST) begin
                        active <= 1'b0;
                    end
                end
            end else begin
                div_cnt <= div_cnt - DIV_W'(1);
            end
        end
    end
endmodule

// File: rtl/adc_sample_accum.sv
// adc_sample_accum
//   Measurement capture engine: on a meas_start rising edge runs
//   2^AVG_LOG2 serial ADC conversions, accumulates and averages them and
//   publishes the result to the CPU data path.
//   CLK, RST_N : clock, async active-low reset
//   ANA_SI     : ADC serial data, MSB first
//   ADC_CONV   : one-cycle conversion strobe
//   SCLK_ADC   : serial clock to the ADC
//   meas       : CPU handshake (adc_sample_accum_if.slave)
//   Build option: define ADC_AVG_ROUND_EN for round-half-up averaging;
//   otherwise the average truncates.
module adc_sample_accum
    import adc_capture_pkg::*;
#(
    parameter int ADC_BITS          = DEF_ADC_BITS,
    parameter int AVG_LOG2          = DEF_AVG_LOG2,
    parameter int DIV_HALF          = DEF_DIV_HALF,
    parameter int CONV_WAIT         = DEF_CONV_WAIT,
    parameter int GENERAL_REG_WIDTH = DEF_GENERAL_REG_WIDTH
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              ANA_SI,
    output logic              ADC_CONV,
    output logic              SCLK_ADC,
    adc_sample_accum_if.slave meas
);
    localparam int N_SAMP = 1 << AVG_LOG2;
    localparam int ACC_W  = ADC_BITS + AVG_LOG2;
    localparam int CNT_W  = AVG_LOG2 + 1;
    localparam int WAIT_W = cnt_width(CONV_WAIT - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(N_SAMP - 1);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(CONV_WAIT - 1);
`ifdef ADC_AVG_ROUND_EN
    localparam logic [ACC_W-1:0] ROUND_ADD = ACC_W'((1 << AVG_LOG2) >> 1);
`else
    localparam logic [ACC_W-1:0] ROUND_ADD = '0;
`endif

    meas_state_e                  state;
    logic                         meas_start_q;
    logic [ACC_W-1:0]             acc;
    logic [CNT_W-1:0]             samp_cnt;
    logic [WAIT_W-1:0]            wait_cnt;
    logic                         start_ok;
    logic                         rx_start;
    logic                         rx_done;
    logic [ADC_BITS-1:0]          rx_data;
    logic [GENERAL_REG_WIDTH-1:0] result_next;

    always_comb begin
        start_ok    = 1'b0;
        rx_start    = 1'b0;
        result_next = '0;
        start_ok    = meas.meas_start && !meas_start_q &&
                      ((state == ST_IDLE) || (state == ST_DONE));
        rx_start    = (state == ST_WAIT) && (wait_cnt == '0);
        // Max sum plus half still fits ACC_W, so no saturation.
        result_next = GENERAL_REG_WIDTH'((acc + ROUND_ADD) >> AVG_LOG2);
    end

    adc_serial_rx #(
        .ADC_BITS (ADC_BITS),
        .DIV_HALF (DIV_HALF)
    ) u_rx (
        .clk    (CLK),
        .rst_n  (RST_N),
        .start  (rx_start),
        .ana_si (ANA_SI),
        .done   (rx_done),
        .sclk   (SCLK_ADC),
        .data   (rx_data)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state             <= ST_IDLE;
            meas_start_q      <= 1'b0;
            ADC_CONV          <= 1'b0;
            meas.meas_busy    <= 1'b0;
            meas.meas_is_done <= 1'b0;
            meas.meas_result  <= '0;
            acc               <= '0;
            samp_cnt          <= '0;
            wait_cnt          <= '0;
        end else begin
            meas_start_q <= meas.meas_start;
            ADC_CONV     <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    // Result is reloaded from the held accumulator while in
                    // DONE, so it first appears one cycle after entry and
                    // stays frozen throughout the following run.
                    if (state == ST_DONE) begin
                        meas.meas_result <= result_next;
                    end
                    if (start_ok) begin
                        state             <= ST_CONV;
                        ADC_CONV          <= 1'b1;
                        acc               <= '0;
                        samp_cnt          <= '0;
                        meas.meas_busy    <= 1'b1;
                        meas.meas_is_done <= 1'b0;
                    end else if (state == ST_DONE) begin
                        meas.meas_busy    <= 1'b0;
                        meas.meas_is_done <= 1'b1;
                    end
                end
                ST_CONV: begin
                    state    <= ST_WAIT;
                    wait_cnt <= WAIT_LOAD;
                end
                ST_WAIT: begin
                    if (wait_cnt == '0) begin
                        state <= ST_SHIFT;
                    end else begin
                        wait_cnt <= wait_cnt - WAIT_W'(1);
                    end
                end
                ST_SHIFT: begin
                    if (rx_done) begin
                        state <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    acc      <= acc + ACC_W'(rx_data);
                    samp_cnt <= samp_cnt + CNT_W'(1);
                    if (samp_cnt == CNT_LAST) begin
                        state <= ST_DONE;
                    end else begin
                        state    <= ST_CONV;
                        ADC_CONV <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adc_sample_accum.sv
// tb_adc_sample_accum
//   Self-checking bench: two instances (default build, and AVG_LOG2=0 /
//   DIV_HALF=1), each fed by a behavioural serial ADC that plays samples
//   from a queue. Expected averages come from plain arithmetic on the
//   queued samples; latencies from the per-sample cycle formula.
module tb_adc_sample_accum;
    import adc_capture_pkg::*;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    logic ana_si1 = 1'b0;
    logic ana_si2 = 1'b0;
    logic adc_conv1, sclk1, adc_conv2, sclk2;

    adc_sample_accum_if #(.GENERAL_REG_WIDTH(16)) m1 ();
    adc_sample_accum_if #(.GENERAL_REG_WIDTH(16)) m2 ();

    adc_sample_accum #(
        .ADC_BITS(10), .AVG_LOG2(2), .DIV_HALF(2), .CONV_WAIT(8), .GENERAL_REG_WIDTH(16)
    ) dut1 (
        .CLK(CLK), .RST_N(RST_N), .ANA_SI(ana_si1),
        .ADC_CONV(adc_conv1), .SCLK_ADC(sclk1), .meas(m1.slave)
    );

    adc_sample_accum #(
        .ADC_BITS(10), .AVG_LOG2(0), .DIV_HALF(1), .CONV_WAIT(8), .GENERAL_REG_WIDTH(16)
    ) dut2 (
        .CLK(CLK), .RST_N(RST_N), .ANA_SI(ana_si2),
        .ADC_CONV(adc_conv2), .SCLK_ADC(sclk2), .meas(m2.slave)
    );

    // Behavioural ADCs
    int unsigned q1[$];
    int unsigned q2[$];
    int unsigned conv_cnt1 = 0;
    int unsigned conv_cnt2 = 0;
    logic [9:0]  cur1 = '0;
    logic [9:0]  cur2 = '0;
    int          bidx1 = 0;
    int          bidx2 = 0;
    logic        sclk1_prev = 1'b0;
    logic        sclk2_prev = 1'b0;

    always @(negedge CLK) begin
        if (adc_conv1) begin
            cur1 = (q1.size() > 0) ? 10'(q1.pop_front()) : 10'd0;
            bidx1 = 9;
            ana_si1 = cur1[bidx1];
            conv_cnt1++;
        end else if (sclk1 && !sclk1_prev && bidx1 > 0) begin
            bidx1--;
            ana_si1 = cur1[bidx1];
        end
        sclk1_prev = sclk1;
    end

    always @(negedge CLK) begin
        if (adc_conv2) begin
            cur2 = (q2.size() > 0) ? 10'(q2.pop_front()) : 10'd0;
            bidx2 = 9;
            ana_si2 = cur2[bidx2];
            conv_cnt2++;
        end else if (sclk2 && !sclk2_prev && bidx2 > 0) begin
            bidx2--;
            ana_si2 = cur2[bidx2];
        end
        sclk2_prev = sclk2;
    end

    int unsigned n_total = 0;
    int unsigned n_bad = 0;
    int unsigned last_exp1 = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned avg_ref(input int unsigned sum, input int unsigned l);
`ifdef ADC_AVG_ROUND_EN
        return (sum + ((32'd1 << l) >> 1)) >> l;
`else
        return sum >> l;
`endif
    endfunction

    // One 4-sample run on dut1 using the samples already queued in q1.
    task automatic run1(input string tag, input bit hold, input bit inject);
        int unsigned sum;
        int unsigned exp;
        int unsigned conv0;
        int unsigned n;
        int unsigned unstable;
        sum = 0;
        foreach (q1[i]) sum += q1[i];
        exp = avg_ref(sum, 2);
        conv0 = conv_cnt1;
        @(negedge CLK);
        m1.meas_start = 1'b1;
        @(posedge CLK);
        #1;
        check_eq({tag, " done@accept"}, 32'(m1.meas_is_done), 32'd0);
        check_eq({tag, " busy@accept"}, 32'(m1.meas_busy), 32'd1);
        if (!hold) begin
            @(negedge CLK);
            m1.meas_start = 1'b0;
        end
        if (inject) begin
            fork
                begin
                    repeat (14) @(negedge CLK);
                    m1.meas_start = 1'b1;
                    repeat (3) @(negedge CLK);
                    m1.meas_start = 1'b0;
                end
            join_none
        end
        n = 0;
        unstable = 0;
        while (n < 1000) begin
            @(posedge CLK);
            #1;
            n++;
            if (m1.meas_is_done) break;
            if (m1.meas_result !== 16'(last_exp1)) unstable++;
        end
        check_eq({tag, " latency"}, n, 32'd201);
        check_eq({tag, " result"}, 32'(m1.meas_result), exp);
        check_eq({tag, " busy@done"}, 32'(m1.meas_busy), 32'd0);
        check_eq({tag, " conv count"}, conv_cnt1 - conv0, 32'd4);
        check_eq({tag, " result held"}, unstable, 32'd0);
        last_exp1 = exp;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned conv0;
        int unsigned n;
        m1.meas_start = 1'b0;
        m2.meas_start = 1'b0;
        RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        check_eq("rst adc_conv", 32'(adc_conv1), 32'd0);
        check_eq("rst sclk", 32'(sclk1), 32'd0);
        check_eq("rst busy", 32'(m1.meas_busy), 32'd0);
        check_eq("rst done", 32'(m1.meas_is_done), 32'd0);
        check_eq("rst result", 32'(m1.meas_result), 32'd0);
        check_eq("rst2 done", 32'(m2.meas_is_done), 32'd0);
        check_eq("rst2 result", 32'(m2.meas_result), 32'd0);
        RST_N = 1'b1;

        repeat (4) q1.push_back(32'h2AB);
        run1("r2ab", 1'b0, 1'b0);

        q1.push_back(1); q1.push_back(2); q1.push_back(2); q1.push_back(2);
        run1("r1222", 1'b0, 1'b0);

        repeat (4) q1.push_back(32'h3FF);
        run1("r3ff", 1'b0, 1'b0);
        check_eq("r3ff upper", 32'(m1.meas_result[15:10]), 32'd0);

        repeat (4) q1.push_back($urandom_range(0, 1023));
        run1("rinject", 1'b0, 1'b1);

        repeat (4) q1.push_back($urandom_range(0, 1023));
        run1("rhold", 1'b1, 1'b0);
        conv0 = conv_cnt1;
        repeat (30) @(posedge CLK);
        #1;
        check_eq("hold still done", 32'(m1.meas_is_done), 32'd1);
        check_eq("hold no conv", conv_cnt1 - conv0, 32'd0);
        @(negedge CLK);
        m1.meas_start = 1'b0;

        for (int r = 0; r < 4; r++) begin
            repeat (4) q1.push_back($urandom_range(0, 1023));
            run1($sformatf("rrand%0d", r), 1'b0, 1'b0);
        end

        // Reset in the middle of sample 3's serial shift
        repeat (4) q1.push_back($urandom_range(0, 1023));
        @(negedge CLK);
        m1.meas_start = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        m1.meas_start = 1'b0;
        repeat (119) @(posedge CLK);
        #2;
        check_eq("pre-rst busy", 32'(m1.meas_busy), 32'd1);
        check_eq("pre-rst sclk", 32'(sclk1), 32'd1);
        RST_N = 1'b0;
        #1;
        check_eq("midrst adc_conv", 32'(adc_conv1), 32'd0);
        check_eq("midrst sclk", 32'(sclk1), 32'd0);
        check_eq("midrst busy", 32'(m1.meas_busy), 32'd0);
        check_eq("midrst done", 32'(m1.meas_is_done), 32'd0);
        check_eq("midrst result", 32'(m1.meas_result), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        q1.delete();
        last_exp1 = 0;
        repeat (4) q1.push_back(32'h155);
        run1("r155", 1'b0, 1'b0);

        // Single-sample, fast-clock instance
        q2.push_back(1);
        conv0 = conv_cnt2;
        @(negedge CLK);
        m2.meas_start = 1'b1;
        @(posedge CLK);
        #1;
        check_eq("d2 busy@accept", 32'(m2.meas_busy), 32'd1);
        @(negedge CLK);
        m2.meas_start = 1'b0;
        n = 0;
        while (n < 1000) begin
            @(posedge CLK);
            #1;
            n++;
            if (m2.meas_is_done) break;
        end
        check_eq("d2 latency", n, 32'd31);
        check_eq("d2 result", 32'(m2.meas_result), avg_ref(1, 0));
        check_eq("d2 conv count", conv_cnt2 - conv0, 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
